// File: rtl/ysyx_22040759_dsram.sv
// Data-memory responder for the MEM stage: one request at a time, fixed programmable
// latency, lane-aligned stores and sign/zero-extended loads on a doubleword array.
module ysyx_22040759_dsram #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE       = 64'h8000_0000,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam logic [63:0] SPAN = 64'(1) << (DEPTH_LOG2 + 3);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        r_wen, r_unsigned;
    logic [1:0]  r_size;
    logic [63:0] r_addr, r_wdata;

    logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

    logic                  accept, commit;
    logic [63:0]           offset;
    logic [DEPTH_LOG2-1:0] index;
    logic [2:0]            lane;
    logic [5:0]            shamt;
    logic                  misaligned, err;
    logic [7:0]            strb;
    logic [63:0]           wdata_sh, rd_sh, load_val;

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign commit     = (state == WAIT) && (cnt == 4'd0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = WAIT;
            WAIT: if (cnt == 4'd0) state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address decode and data alignment for the latched request.
    always_comb begin
        offset = r_addr - BASE;
        index  = offset[DEPTH_LOG2+2:3];
        lane   = r_addr[2:0];
        shamt  = {lane, 3'b000};
        case (r_size)
            2'd0:    begin misaligned = 1'b0;                strb = 8'h01; end
            2'd1:    begin misaligned = r_addr[0];           strb = 8'h03; end
            2'd2:    begin misaligned = |r_addr[1:0];        strb = 8'h0F; end
            default: begin misaligned = |r_addr[2:0];        strb = 8'hFF; end
        endcase
        strb     = strb << lane;
        err      = (r_addr < BASE) || (offset >= SPAN) || misaligned;
        wdata_sh = r_wdata << shamt;
        rd_sh    = mem[index] >> shamt;
        case (r_size)
            2'd0:    load_val = r_unsigned ? {56'd0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
            2'd1:    load_val = r_unsigned ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
            2'd2:    load_val = r_unsigned ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
            default: load_val = rd_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                resp_err   <= err;
                resp_rdata <= (err || r_wen) ? '0 : load_val;
            end
        end
    end

    // Request fields are only consumed in WAIT, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            r_wen      <= req_wen;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && r_wen && !err) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (strb[b]) mem[index][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
    end
endmodule

// File: doc/ysyx_22040759_dsram.md
# ysyx_22040759_dsram

Data-memory responder for the MEM stage of the ysyx_22040759 five-stage core; the other end of the stage's load/store request. It accepts one request at a time over a valid/ready handshake. After a programmable latency it performs a lane-aligned store or a sign/zero-extended load on an internal doubleword array. It then returns the result over a valid/ready response channel. Misaligned or out-of-range accesses are flagged instead of touching memory.

## Interface
Parameters:
- DEPTH_LOG2, 12, log2 of the number of 64-bit doublewords (default 32 KiB)
- BASE, 64'h8000_0000, byte address of doubleword 0
- LATENCY, 1, cycles from request accept to resp_valid; legal 1..15

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword
- req_unsigned  in  1  load zero-extends when 1; ignored for stores and for size 3
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned (low bytes significant)
- resp_valid  out  1  response present
- resp_ready  in  1  initiator accepts the response
- resp_rdata  out  64  load result, extended to 64 bits; 0 for stores and errors
- resp_err  out  1  access was misaligned or out of range

## Operation
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state == IDLE) && !rst.
- Accept: req_valid && req_ready. The block registers wen, size, unsigned, addr and wdata, loads the counter with LATENCY-1, and moves to WAIT. If LATENCY == 1, it goes straight to the commit step on the next edge.
- WAIT: the counter decrements each cycle. When the counter reaches 0, the commit step runs at the next edge and the FSM enters RESP.
- Commit step:
  - Offset = addr - BASE; index = offset[DEPTH_LOG2+2:3]; lane = addr[2:0].
  - err = 1 if addr < BASE, or offset ≥ 8·2^DEPTH_LOG2, or addr is not aligned to the access size (addr & ((1<<size)-1) != 0).
  - Store with no error: byte strobes = ((1<<(1<<size))-1) << lane. The bytes of wdata shifted left by 8·lane are written into array[index] under those strobes; other bytes are unchanged.
  - Load with no error: the doubleword is shifted right by 8·lane, truncated to 8·2^size bits, and extended. Extension is sign-extension unless req_unsigned is 1 or size is 3.
  - On error: no array write, resp_rdata = 0, resp_err = 1.
- RESP: resp_valid = 1. resp_rdata and resp_err are held stable until resp_valid && resp_ready, then the FSM returns to IDLE.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state = IDLE, resp_valid = 0, resp_rdata = 0, resp_err = 0, counter = 0; req_ready = 0 while rst is high.
- Latency: a request accepted on edge t gives resp_valid = 1 from cycle t+LATENCY onward.
- Throughput: if resp_ready is high on the first response cycle, req_ready returns in the following cycle. A new request is accepted at most every LATENCY+1 cycles.
- Stores commit to the array on the same edge that raises resp_valid. A load issued after the store's response sees the stored data.
- The request channel has no effect outside IDLE. Request inputs may change freely while req_ready = 0.
- Backpressure: with resp_ready = 0 the block stays in RESP indefinitely and all response outputs stay constant.
- Reset mid-transaction: the FSM returns to IDLE on the next edge. A store still in WAIT is dropped. A store already committed (RESP) stays in the array. The pending response is discarded.
- Simultaneous rst and req_valid: rst wins; no request is accepted.

## Test plan
- Reset: hold rst for 2 cycles with req_valid = 1 → req_ready = 0, resp_valid = 0, no accept; after release, req_ready = 1 in the first cycle.
- LATENCY = 1, sd 0x8000_0008 ← 0x1122_3344_5566_7788, then ld 0x8000_0008 → store response at accept+1 with err = 0 and rdata = 0; load rdata = 0x1122_3344_5566_7788.
- Continuing from the previous scenario:
  - lb 0x8000_0008 → rdata = 0xFFFF_FFFF_FFFF_FF88.
  - lbu 0x8000_0008 → rdata = 0x88.
  - lw 0x8000_000C → rdata = 0x1122_3344.
- sh 0x8000_000A ← 0xABCD, then ld 0x8000_0008 → rdata = 0x1122_3344_ABCD_7788; other bytes unchanged.
- Errors:
  - lw 0x8000_0002 → err = 1, rdata = 0.
  - sd 0x7FFF_FFF8 → err = 1, and the array is unchanged, checked by rereading 0x8000_0008.
- LATENCY = 4 with resp_ready held low for 3 response cycles → resp_valid rises at accept+4; rdata and err are stable while stalled and req_ready stays 0. With rst pulsed during WAIT of a store, a later load returns the old data.
